// File: rtl/adder_pkg.sv
// Shared defaults and the per-stage pipeline record used by pipelined_adder.
package adder_pkg;
    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STAGES = 2;
    // Record fields are sized for the widest supported adder; narrower builds use the low bits.
    localparam int MAX_WIDTH      = 64;

    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [MAX_WIDTH-1:0] psum;
        logic [MAX_WIDTH-1:0] pendA;
        logic [MAX_WIDTH-1:0] pendB;
    } stage_t;
endpackage

// File: rtl/adder_stage.sv
// Combinational CW-bit chunk adder with carry in and carry out.
module adder_stage #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          carry_i,
    output logic [CW-1:0] sum_o,
    output logic          carry_o
);
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, carry_i};
endmodule

// File: rtl/pipelined_adder.sv
// Valid/ready pipelined ripple adder, one CW-bit chunk per stage, LSB chunk first.
// Define ADDER_OVERFLOW_EN to add a signed-overflow output aligned with sum.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    stage_t            pipe_q [STAGES];
    stage_t            pipe_d [STAGES];
    stage_t            src    [STAGES];
    logic [STAGES-1:0] stageReady;
    logic [CW-1:0]     opA      [STAGES];
    logic [CW-1:0]     opB      [STAGES];
    logic [CW-1:0]     chunkSum [STAGES];
    logic              carryIn  [STAGES];
    logic              carryOut [STAGES];
    logic              readyChain;

    // Stage 0 is fed by the input port; every later stage by its predecessor's register.
    always_comb begin
        src[0]                  = '0;
        src[0].valid            = in_valid;
        src[0].carry            = cin;
        src[0].pendA[WIDTH-1:0] = a;
        src[0].pendB[WIDTH-1:0] = b;
        for (int s = 1; s < STAGES; s++) begin
            src[s] = pipe_q[s-1];
        end
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            opA[s]     = src[s].pendA[s*CW +: CW];
            opB[s]     = src[s].pendB[s*CW +: CW];
            carryIn[s] = src[s].carry;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : gStage
        adder_stage #(.CW(CW)) uStage (
            .a_i     (opA[s]),
            .b_i     (opB[s]),
            .carry_i (carryIn[s]),
            .sum_o   (chunkSum[s]),
            .carry_o (carryOut[s])
        );
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            pipe_d[s]                  = src[s];
            pipe_d[s].carry            = carryOut[s];
            pipe_d[s].psum[s*CW +: CW] = chunkSum[s];
        end
    end

    // A stage can take new content when it is empty or everything downstream of it moves.
    always_comb begin
        stageReady = '0;
        readyChain = out_ready;
        for (int s = LAST; s >= 0; s--) begin
            stageReady[s] = !pipe_q[s].valid || readyChain;
            readyChain    = stageReady[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (stageReady[s]) begin
                    if (src[s].valid) begin
                        pipe_q[s] <= pipe_d[s];
                    end else begin
                        pipe_q[s].valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign in_ready  = stageReady[0];
    assign out_valid = pipe_q[LAST].valid;
    assign sum       = pipe_q[LAST].psum[WIDTH-1:0];
    assign cout      = pipe_q[LAST].carry;

`ifdef ADDER_OVERFLOW_EN
    // Operand sign bits travel with the transaction, so overflow derives from the output record.
    assign overflow = (pipe_q[LAST].pendA[WIDTH-1] == pipe_q[LAST].pendB[WIDTH-1]) &&
                      (pipe_q[LAST].psum[WIDTH-1]  != pipe_q[LAST].pendA[WIDTH-1]);
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed-vector bench for pipelined_adder (WIDTH=8, STAGES=2); checks overflow when ADDER_OVERFLOW_EN is defined.
module tb_pipelined_adder;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVERFLOW_EN
    logic             overflow;
`endif

    int         errCount   = 0;
    int         checkCount = 0;
    logic [8:0] expQ[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] expSum;
        logic       expCout;
        logic       expOvf;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef ADDER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] va, input logic [7:0] vb, input logic vc);
        in_valid = v;
        a        = va;
        b        = vb;
        cin      = vc;
    endtask

    function automatic logic [8:0] refAdd(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {8'd0, c};
    endfunction

    // One clock: scoreboard the handshakes seen just before the edge, then step past it.
    task automatic stepCycle(output bit accepted, output bit emitted);
        logic [8:0] expected;
        #1;
        accepted = in_valid && in_ready;
        emitted  = out_valid && out_ready;
        if (emitted) begin
            if (expQ.size() == 0) begin
                checkCount++;
                errCount++;
                $display("[TB] FAIL unexpected_output: got 0x%0h, expected none", {cout, sum});
            end else begin
                expected = expQ.pop_front();
                checkOutput("stream_result", 32'({cout, sum}), 32'(expected));
            end
        end
        if (accepted) expQ.push_back(refAdd(a, b, cin));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit         acc;
        bit         emi;
        int         lat;
        int         idx;
        int         cyc;
        int         first;
        int         last;
        int         emits;
        int         accepts;
        int         ghost;
        logic [7:0] sa[16];
        logic [7:0] sb[16];
        logic       sc[16];

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sum",       32'(sum),       32'd0);
        checkOutput("reset_cout",      32'(cout),      32'd0);
        checkOutput("reset_in_ready",  32'(in_ready),  32'd1);

        // Isolated transactions: latency, arithmetic and wrap corners.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
            #1;
            checkOutput("vec_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            applyStimulus(1'b0, 8'hAA, 8'h55, 1'b1);
            lat = 1;
            while (!out_valid && lat < 8) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checkOutput("vec_latency", 32'(lat), 32'(STAGES));
            checkOutput("vec_sum",     32'(sum),  32'(vecs[i].expSum));
            checkOutput("vec_cout",    32'(cout), 32'(vecs[i].expCout));
`ifdef ADDER_OVERFLOW_EN
            checkOutput("vec_overflow", 32'(overflow), 32'(vecs[i].expOvf));
`endif
            @(posedge clk);
            #1;
            checkOutput("vec_drained", 32'(out_valid), 32'd0);
        end

        // Back-to-back stream of 16 random operands with the consumer always ready.
        for (int i = 0; i < 16; i++) begin
            sa[i] = 8'($urandom);
            sb[i] = 8'($urandom);
            sc[i] = 1'($urandom);
        end
        expQ.delete();
        idx   = 0;
        cyc   = 0;
        first = -1;
        last  = -1;
        emits = 0;
        while ((idx < 16 || expQ.size() > 0) && cyc < 60) begin
            if (idx < 16) applyStimulus(1'b1, sa[idx], sb[idx], sc[idx]);
            else          applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
            stepCycle(acc, emi);
            if (acc) idx++;
            if (emi) begin
                if (first < 0) first = cyc;
                last = cyc;
                emits++;
            end
            cyc++;
        end
        checkOutput("stream_count",     32'(emits),      32'd16);
        checkOutput("stream_span",      32'(last-first), 32'd15);
        checkOutput("stream_first_lat", 32'(first),      32'(STAGES));

        // Backpressure: consumer stalls while the producer keeps offering.
        expQ.delete();
        out_ready = 1'b0;
        idx       = 0;
        accepts   = 0;
        emits     = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, sa[idx], sb[idx], sc[idx]);
            stepCycle(acc, emi);
            if (acc) begin
                idx++;
                accepts++;
            end
            if (out_valid && expQ.size() > 0) begin
                checkOutput("stall_hold", 32'({out_valid, cout, sum}), 32'({1'b1, expQ[0]}));
            end
        end
        checkOutput("bp_accepts",  32'(accepts),   32'(STAGES));
        checkOutput("bp_in_ready", 32'(in_ready),  32'd0);
        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);

        // Releasing a full pipeline must accept and emit in the same cycle.
        out_ready = 1'b1;
        applyStimulus(1'b1, sa[idx], sb[idx], sc[idx]);
        #1;
        checkOutput("simul_in_ready", 32'(in_ready), 32'd1);
        stepCycle(acc, emi);
        checkOutput("simul_accept_emit", 32'({acc, emi}), 32'd3);
        if (acc) idx++;
        if (emi) emits++;
        cyc = 0;
        while ((idx < 6 || expQ.size() > 0) && cyc < 30) begin
            if (idx < 6) applyStimulus(1'b1, sa[idx], sb[idx], sc[idx]);
            else         applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
            stepCycle(acc, emi);
            if (acc) idx++;
            if (emi) emits++;
            cyc++;
        end
        checkOutput("bp_total_out", 32'(emits),       32'd6);
        checkOutput("bp_queue_left", 32'(expQ.size()), 32'd0);

        // Reset asserted with transactions in flight must discard them.
        expQ.delete();
        out_ready = 1'b0;
        applyStimulus(1'b1, 8'h11, 8'h22, 1'b0);
        stepCycle(acc, emi);
        applyStimulus(1'b1, 8'h33, 8'h44, 1'b1);
        stepCycle(acc, emi);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_reset_sum",       32'(sum),       32'd0);
        checkOutput("mid_reset_cout",      32'(cout),      32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        expQ.delete();
        out_ready = 1'b1;
        ghost     = 0;
        for (int c = 0; c < 6; c++) begin
            stepCycle(acc, emi);
            if (emi) ghost++;
        end
        checkOutput("post_reset_no_output", 32'(ghost),    32'd0);
        checkOutput("post_reset_in_ready",  32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/sum width in bits (>=2).
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth in register stages (1..WIDTH, WIDTH % STAGES == 0).
REQ-003 SHALL have clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have in_valid  input  1  operands a, b, cin presented.
REQ-006 SHALL have in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have a  input  WIDTH  operand A, unsigned.
REQ-008 SHALL have b  input  WIDTH  operand B, unsigned.
REQ-009 SHALL have cin  input  1  carry in.
REQ-010 SHALL have out_valid  output  1  sum/cout hold a valid result.
REQ-011 SHALL have out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have sum  output  WIDTH  result bits, (a+b+cin) mod 2^WIDTH.
REQ-013 SHALL have cout  output  1  carry out of the MSB.

Function
REQ-014 SHALL split operands into STAGES chunks of CW=WIDTH/STAGES bits; stage k adds chunk k (LSB first) with the carry registered by stage k-1.
REQ-015 SHALL delay unconsumed upper operand chunks alongside their transaction so results never mix transactions.
REQ-016 SHALL transfer input on in_valid && in_ready; output on out_valid && out_ready.
REQ-017 SHALL give latency exactly STAGES cycles from accepted input to out_valid with out_ready held high.
REQ-018 SHALL hold one valid bit per stage; stage k advances when its successor is empty or advancing (last stage advances on out_ready or when empty).
REQ-019 SHALL drive in_ready = !valid[0] || advance[0] combinationally; no combinational path from in_valid to in_ready.
REQ-020 SHALL sustain one transaction per cycle with out_ready held high; capacity is STAGES transactions when stalled.
REQ-021 SHALL hold sum, cout and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL accept a new input in the same cycle a full pipeline drains one output (simultaneous accept/emit).
REQ-023 SHALL produce correct carry at full-scale wrap: a=b=2^WIDTH-1, cin=1 gives sum=2^WIDTH-1, cout=1.
REQ-024 SHALL ignore a, b, cin whenever in_valid is low or in_ready is low.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear all stage valid bits, carries and data registers; out_valid=0, sum=0, cout=0, in_ready=1 after reset release.
REQ-026 SHALL discard all in-flight transactions when reset asserts mid-operation; no result emitted for them.

Configuration
REQ-027 SHALL, with ADDER_OVERFLOW_EN defined, add output overflow (1 bit) = signed two's-complement overflow of a+b+cin, pipelined with sum, reset 0.
REQ-028 SHALL, without ADDER_OVERFLOW_EN, omit the overflow port and its logic entirely.

Structure
REQ-029 SHALL place default WIDTH/STAGES constants and a stage record typedef (valid, carry, partial sum, pending operand chunks) in package adder_pkg.
REQ-030 SHALL instantiate sub-module adder_stage (CW-bit chunk add with carry in/out, combinational) once per stage.

Verification
REQ-031 SHALL cover reset: rst_n=0 then 1 -> out_valid=0, sum=0, cout=0, in_ready=1.
REQ-032 SHALL cover single add (WIDTH=8, STAGES=2): a=8'h0F, b=8'h01, cin=0 -> after 2 cycles sum=8'h10, cout=0.
REQ-033 SHALL cover wrap: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1; a=b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-034 SHALL cover back-to-back stream of 16 random pairs with out_ready=1 -> 16 results in order, one per cycle, matching reference model.
REQ-035 SHALL cover backpressure: out_ready=0 for 5 cycles while in_valid=1 -> in_ready falls after STAGES accepts, output held stable, no loss or duplication on release.
REQ-036 SHALL cover ADDER_OVERFLOW_EN: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, overflow=1; a=8'h80, b=8'h80 -> sum=8'h00, cout=1, overflow=1.
